// File: rtl/report_stream_parser.sv
// Parses an ASCII byte stream of blank-separated decimal numbers into one value per
// en_processor strobe; a one-value lookahead lets the newline flag ride on each report's final value.
module report_stream_parser #(
  parameter int VAL_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [VAL_W-1:0] read_val,
  output logic             en_processor,
  output logic             newline,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] value_count,
  output logic             err_bad_char,
  output logic             err_overflow,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, NUM, GAP, FLUSH, DONE} state_t;

  state_t           state;
  logic [VAL_W-1:0] acc;
  logic [VAL_W-1:0] pend;
  logic             pend_v;
  logic             last_pend;

  logic             accept;
  logic             is_digit, is_blank, is_lf, is_cr, is_bad;
  logic             ends_line, completes, dig_ovf;
  logic [VAL_W+3:0] prod;
  logic [VAL_W+3:0] max_ext;
  logic [VAL_W-1:0] acc_dig, tok;

  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_blank = (in_data == 8'h20) || (in_data == 8'h09);
  assign is_lf    = (in_data == 8'h0A);
  assign is_cr    = (in_data == 8'h0D);
  assign is_bad   = !(is_digit || is_blank || is_lf || is_cr);

  // ASCII digits 0x30-0x39 carry their value in the low nibble.
  assign max_ext = {4'b0, {VAL_W{1'b1}}};
  assign prod    = {4'b0, acc} * (VAL_W+4)'(10) + (VAL_W+4)'(in_data[3:0]);
  assign dig_ovf = prod > max_ext;
  assign acc_dig = dig_ovf ? {VAL_W{1'b1}} : prod[VAL_W-1:0];
  assign tok     = is_digit ? acc_dig : acc;

  // A CR is transparent unless it carries in_last, which closes the line like LF.
  assign ends_line = is_lf || in_last;
  assign completes = (is_digit && in_last) ||
                     ((state == NUM) && !is_digit && (!is_cr || in_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      pend         <= '0;
      pend_v       <= 1'b0;
      last_pend    <= 1'b0;
      in_ready     <= 1'b0;
      read_val     <= '0;
      en_processor <= 1'b0;
      newline      <= 1'b0;
      line_count   <= '0;
      value_count  <= '0;
      err_bad_char <= 1'b0;
      err_overflow <= 1'b0;
      done         <= 1'b0;
    end else begin
      en_processor <= 1'b0;
      case (state)
        IDLE, NUM, GAP: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (is_bad) err_bad_char <= 1'b1;
            if (is_digit) begin
              acc <= acc_dig;
              if (dig_ovf) err_overflow <= 1'b1;
            end
            if (completes) begin
              if (pend_v) begin
                read_val     <= pend;
                newline      <= 1'b0;
                en_processor <= 1'b1;
                if (~&value_count) value_count <= value_count + 1'b1;
              end
              pend   <= tok;
              pend_v <= 1'b1;
              acc    <= '0;
            end
            if (ends_line) begin
              if (completes || pend_v) begin
                state     <= FLUSH;
                in_ready  <= 1'b0;
                last_pend <= in_last;
              end else if (in_last) begin
                state    <= DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else if (is_digit) begin
              state <= NUM;
            end else if (!is_cr && (state == NUM)) begin
              state <= GAP;
            end
          end
        end
        FLUSH: begin
          read_val     <= pend;
          newline      <= 1'b1;
          en_processor <= 1'b1;
          pend_v       <= 1'b0;
          if (~&value_count) value_count <= value_count + 1'b1;
          if (~&line_count)  line_count  <= line_count + 1'b1;
          if (last_pend) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        DONE: in_ready <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
